// File: rtl/reram_xbar_responder.sv
// reram_xbar_responder: behavioural ReRAM crossbar MAC engine.
// Holds a signed 8-bit weight array (OUTPUT_SIZE x INPUT_SIZE) and an unsigned
// 8-bit input vector. Each accepted compute request runs a serial MAC over one
// row, then returns a saturated signed 16-bit result.
//
// Request/response handshake: xbar_compute is a one-cycle request pulse that is
// sampled only while the FSM is in IDLE. Pulses seen in any other state are
// dropped and never queued. Every accepted request produces exactly one
// one-cycle xbar_valid pulse, with xbar_err high on that same cycle if the
// request was rejected. busy is high from the accept edge until the edge where
// xbar_valid falls. There is no backpressure on the response.
//
// dbg_state exposes the FSM state: 0=IDLE, 1=MAC, 2=SAT, 3=RESP.
module reram_xbar_responder #(
  parameter int INPUT_SIZE  = 784,
  parameter int OUTPUT_SIZE = 256,
  parameter int SHIFT       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_row,
  input  logic [15:0] wr_col,
  input  logic [7:0]  wr_data,
  input  logic        vec_clear,
  input  logic        vec_valid,
  input  logic [7:0]  vec_data,
  output logic        vec_full,
  output logic        vec_overflow,
  input  logic        xbar_compute,
  input  logic [15:0] xbar_input_idx,
  output logic [15:0] xbar_result,
  output logic        xbar_valid,
  output logic        xbar_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int COL_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int ROW_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int PTR_W = $clog2(INPUT_SIZE + 1);

  localparam logic [31:0] ROW_LIM = OUTPUT_SIZE;
  localparam logic [31:0] COL_LIM = INPUT_SIZE;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(INPUT_SIZE - 1);
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(INPUT_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_SAT  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Storage (not reset: contents survive rst)
  logic signed [7:0] weight [OUTPUT_SIZE][INPUT_SIZE];
  logic        [7:0] vec    [INPUT_SIZE];

  // Control / datapath registers
  state_t             state_q, state_d;
  logic signed [31:0] acc_q, acc_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               pend_err_q, pend_err_d;
  logic [15:0]        result_q, result_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   ptr_q;
  logic               ovf_q;

  logic               idx_ok;
  logic signed [16:0] prod;
  logic signed [31:0] shifted;
  logic [15:0]        sat_val;

  assign vec_full     = (ptr_q == FULL_PTR);
  assign vec_overflow = ovf_q;
  assign xbar_result  = result_q;
  assign xbar_valid   = valid_q;
  assign xbar_err     = err_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

  assign idx_ok = ({16'd0, xbar_input_idx} < ROW_LIM);

  // MAC product and saturation of the shifted accumulator
  always_comb begin
    prod    = $signed({1'b0, vec[col_q]}) * weight[row_q][col_q];
    shifted = acc_q >>> SHIFT;
    if (shifted > 32'sd32767) begin
      sat_val = 16'h7FFF;
    end else if (shifted < -32'sd32768) begin
      sat_val = 16'h8000;
    end else begin
      sat_val = shifted[15:0];
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      pend_err_q <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pend_err_q <= pend_err_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    col_d      = col_q;
    row_d      = row_q;
    pend_err_d = pend_err_q;
    result_d   = result_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // busy drops here, on the same edge the response strobe falls
        busy_d = 1'b0;
        if (xbar_compute) begin
          busy_d = 1'b1;
          acc_d  = '0;
          col_d  = '0;
          row_d  = xbar_input_idx[ROW_W-1:0];
          if (idx_ok && vec_full) begin
            pend_err_d = 1'b0;
            state_d    = S_MAC;
          end else begin
            pend_err_d = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{15{prod[16]}}, prod};
        col_d = col_q + 1'b1;
        if (col_q == LAST_COL) begin
          state_d = S_SAT;
        end
      end
      S_SAT: begin
        result_d = sat_val;
        state_d  = S_RESP;
      end
      S_RESP: begin
        valid_d = 1'b1;
        err_d   = pend_err_q;
        if (pend_err_q) begin
          result_d = '0;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Vector write pointer and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else if (!busy_q) begin
      if (vec_clear) begin
        ptr_q <= '0;
        ovf_q <= 1'b0;
      end else if (vec_valid) begin
        if (vec_full) begin
          ovf_q <= 1'b1;
        end else begin
          ptr_q <= ptr_q + 1'b1;
        end
      end
    end
  end

  // Vector storage write
  always_ff @(posedge clk) begin
    if (!busy_q && !vec_clear && vec_valid && !vec_full) begin
      vec[ptr_q[COL_W-1:0]] <= vec_data;
    end
  end

  // Weight programming, blocked while a request is in flight
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q && ({16'd0, wr_row} < ROW_LIM) && ({16'd0, wr_col} < COL_LIM)) begin
      weight[wr_row[ROW_W-1:0]][wr_col[COL_W-1:0]] <= wr_data;
    end
  end

endmodule
